// File: rtl/spi_secondary_tx_if.sv
// -----------------------------------------------------------------------------
// spi_secondary_tx_if
// Bundles the SPI pins and the upstream source handshake of spi_secondary_tx.
//   spi_sck, spi_cs   : SPI clock / active-low select from the main (async)
//   spi_miso, miso_oe : serial data to the main and its drive enable
//   tx_data, tx_valid : word offered by the source
//   tx_ready          : one-cycle load strobe (word moves when valid & ready)
//   word_sent         : pulse when the last bit of a word was sampled
//   underrun          : pulse when a load happened with no valid word
// Modports: slave = the transmitter itself, master = the main/source side.
// -----------------------------------------------------------------------------
interface spi_secondary_tx_if #(
    parameter int WORD_SIZE = 8
);
    logic                 spi_sck;
    logic                 spi_cs;
    logic                 spi_miso;
    logic                 miso_oe;
    logic [WORD_SIZE-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 word_sent;
    logic                 underrun;

    modport slave (
        input  spi_sck, spi_cs, tx_data, tx_valid,
        output spi_miso, miso_oe, tx_ready, word_sent, underrun
    );

    modport master (
        output spi_sck, spi_cs, tx_data, tx_valid,
        input  spi_miso, miso_oe, tx_ready, word_sent, underrun
    );
endinterface

// File: rtl/spi_secondary_tx.sv
// -----------------------------------------------------------------------------
// spi_secondary_tx
// MISO half of the SPI secondary link (mode 0). Pulls words from an upstream
// source over a valid/ready strobe and shifts them out MSB-first; MISO is
// updated after falling sck so the main can sample it on the rising edge.
// sck and cs are asynchronous to clk and are synchronized here.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : spi_secondary_tx_if.slave (SPI pins + source handshake)
// -----------------------------------------------------------------------------
module spi_secondary_tx #(
    parameter int                   WORD_SIZE   = 8,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [WORD_SIZE-1:0] IDLE_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_secondary_tx_if.slave     bus
);

    localparam int CNT_W = (WORD_SIZE > 2) ? $clog2(WORD_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_SIZE - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    // ------------------------------------------------------------------
    // Synchronizers and edge detection. Presets match an idle bus
    // (sck low, cs high) so leaving reset never fakes an edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_reg;
    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic                   sck_d_reg;
    logic                   cs_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_reg <= '0;
            cs_sync_reg  <= '1;
            sck_d_reg    <= 1'b0;
            cs_d_reg     <= 1'b1;
        end else begin
            sck_sync_reg <= {sck_sync_reg[SYNC_STAGES-2:0], bus.spi_sck};
            cs_sync_reg  <= {cs_sync_reg[SYNC_STAGES-2:0], bus.spi_cs};
            sck_d_reg    <= sck_sync_reg[SYNC_STAGES-1];
            cs_d_reg     <= cs_sync_reg[SYNC_STAGES-1];
        end
    end

    logic sck_s, cs_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
    assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
    assign sck_rise =  sck_s & ~sck_d_reg;
    assign sck_fall = ~sck_s &  sck_d_reg;
    assign cs_rise  =  cs_s  & ~cs_d_reg;
    assign cs_fall  = ~cs_s  &  cs_d_reg;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [1:0]           state_reg, state_next;
    logic [WORD_SIZE-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic                 done_reg, done_next;
    logic                 load_strobe;
    logic                 sent_pulse;

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        cnt_next    = cnt_reg;
        done_next   = done_reg;
        load_strobe = 1'b0;
        sent_pulse  = 1'b0;

        if (cs_rise) begin
            // Deselect wins over any sck edge in the same cycle; a partial
            // word is simply dropped.
            state_next = ST_IDLE;
            cnt_next   = '0;
            done_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_next = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    load_strobe = 1'b1;
                    shift_next  = bus.tx_valid ? bus.tx_data : IDLE_WORD;
                    cnt_next    = '0;
                    state_next  = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sck_rise) begin
                        if (cnt_reg == LAST_BIT) begin
                            sent_pulse = 1'b1;
                            done_next  = 1'b1;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (done_reg) begin
                            // Word finished: fetch the next one right away so
                            // consecutive words run without a gap.
                            done_next  = 1'b0;
                            state_next = ST_LOAD;
                        end else begin
                            shift_next = {shift_reg[WORD_SIZE-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and registered MISO / output enable
    // ------------------------------------------------------------------
    logic miso_reg;
    logic oe_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            miso_reg  <= 1'b0;
            oe_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
            if (cs_rise || state_reg == ST_IDLE) begin
                miso_reg <= 1'b0;
                oe_reg   <= 1'b0;
            end else if (state_reg == ST_SHIFT) begin
                miso_reg <= shift_reg[WORD_SIZE-1];
                oe_reg   <= 1'b1;
            end else begin
                // LOAD between words: keep driving the last bit until the
                // freshly loaded MSB arrives one cycle later.
                oe_reg   <= 1'b1;
            end
        end
    end

    assign bus.spi_miso  = miso_reg;
    assign bus.miso_oe   = oe_reg;
    assign bus.tx_ready  = load_strobe;
    assign bus.underrun  = load_strobe & ~bus.tx_valid;
    assign bus.word_sent = sent_pulse;

endmodule

// File: tb/tb_spi_secondary_tx.sv
module tb_spi_secondary_tx;
    localparam int         WS     = 8;
    localparam int         SS     = 2;
    localparam logic [7:0] IDLE_W = 8'h00;
    localparam int         HP     = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    spi_secondary_tx_if #(.WORD_SIZE(WS)) bus ();

    spi_secondary_tx #(
        .WORD_SIZE  (WS),
        .SYNC_STAGES(SS),
        .IDLE_WORD  (IDLE_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] src_q[$];   // words the source will offer
    logic [7:0] exp_q[$];   // words the main is expected to receive

    int  n_ready = 0, n_sent = 0, n_under = 0, n_under_bad = 0;
    time t_ready = 0, t_fall = 0, t_fall8 = 0;
    bit  pop_pending = 1'b0;

    // Source model and event counters, all observed mid-cycle.
    initial begin
        logic [7:0] dummy;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (pop_pending) begin
                dummy = src_q.pop_front();
                pop_pending = 1'b0;
            end
            if (bus.tx_ready === 1'b1) begin
                n_ready++;
                t_ready = $time;
            end
            if (bus.word_sent === 1'b1) n_sent++;
            if (bus.underrun === 1'b1) begin
                n_under++;
                if (bus.tx_ready !== 1'b1) n_under_bad++;
            end
            if (bus.tx_ready === 1'b1 && bus.tx_valid === 1'b1) begin
                pop_pending = 1'b1;   // hold data through the loading edge
            end else begin
                bus.tx_valid = (src_q.size() > 0);
                bus.tx_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
            end
        end
    end

    // One mode-0 sck pulse; MISO sampled at the rising edge.
    task automatic sck_pulse(input int hp, input bit end_cs, output logic b);
        bus.spi_sck = 1'b1;
        b = bus.spi_miso;
        repeat (hp) @(negedge clk);
        bus.spi_sck = 1'b0;
        if (end_cs) bus.spi_cs = 1'b1;
        t_fall = $time;
        repeat (hp) @(negedge clk);
    endtask

    // Full transfer of nwords under one cs; cs rises with the last sck fall.
    task automatic spi_xfer(input int nwords, input int hp);
        logic       b;
        logic [7:0] w;
        logic [7:0] e;
        int         oe_bad;
        oe_bad = 0;
        bus.spi_cs = 1'b0;
        repeat (hp) @(negedge clk);
        for (int k = 0; k < nwords; k++) begin
            w = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (bus.miso_oe !== 1'b1) oe_bad++;
                sck_pulse(hp, (k == nwords - 1) && (i == 7), b);
                w = {w[6:0], b};
                if (k == 0 && i == 7) t_fall8 = t_fall;
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_word: received %h, required none queued", w);
            end else begin
                e = exp_q.pop_front();
                $display("word rx %h exp %h", w, e);
                if (w !== e) begin
                    errors++;
                    $display("FAIL rx_word: received %h required %h", w, e);
                end
            end
        end
        checks++;
        if (oe_bad != 0) begin
            errors++;
            $display("FAIL miso_oe: low at %0d rising edges, required 0", oe_bad);
        end
        repeat (hp) @(negedge clk);
    endtask

    task automatic check_count(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic test_reset;
        bus.spi_sck = 1'b0;
        bus.spi_cs  = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.spi_miso, bus.miso_oe, bus.tx_ready, bus.word_sent, bus.underrun} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000",
                     {bus.spi_miso, bus.miso_oe, bus.tx_ready, bus.word_sent, bus.underrun});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({bus.spi_miso, bus.miso_oe, bus.tx_ready, bus.word_sent, bus.underrun} !== 5'b0) begin
            errors++;
            $display("FAIL idle_outputs: got %b required 00000",
                     {bus.spi_miso, bus.miso_oe, bus.tx_ready, bus.word_sent, bus.underrun});
        end
    endtask

    task automatic test_single;
        int r0, s0, u0;
        r0 = n_ready; s0 = n_sent; u0 = n_under;
        src_q.push_back(8'hA5);
        exp_q.push_back(8'hA5);
        spi_xfer(1, HP);
        check_count("single_tx_ready", n_ready - r0, 1);
        check_count("single_word_sent", n_sent - s0, 1);
        check_count("single_underrun", n_under - u0, 0);
    endtask

    task automatic test_back_to_back;
        int r0, s0;
        r0 = n_ready; s0 = n_sent;
        src_q.push_back(8'h3C); exp_q.push_back(8'h3C);
        src_q.push_back(8'hC3); exp_q.push_back(8'hC3);
        spi_xfer(2, HP);
        check_count("b2b_tx_ready", n_ready - r0, 2);
        check_count("b2b_word_sent", n_sent - s0, 2);
        // Second load: sck fall crosses SS stages, then one cycle to LOAD.
        check_count("b2b_reload_delay", int'((t_ready - t_fall8) / 10), SS + 1);
    endtask

    task automatic test_underrun;
        int r0, s0, u0, b0;
        r0 = n_ready; s0 = n_sent; u0 = n_under; b0 = n_under_bad;
        exp_q.push_back(IDLE_W);
        spi_xfer(1, HP);
        check_count("udr_underrun", n_under - u0, 1);
        check_count("udr_with_ready", n_under_bad - b0, 0);
        check_count("udr_tx_ready", n_ready - r0, 1);
        check_count("udr_word_sent", n_sent - s0, 1);
    endtask

    task automatic test_abort;
        logic b;
        int   s0;
        s0 = n_sent;
        src_q.push_back(8'hFF);
        bus.spi_cs = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < 3; i++) sck_pulse(HP, 1'b0, b);
        $display("abort after 3 bits of ff");
        checks++;
        if ({bus.miso_oe, bus.spi_miso} !== 2'b11) begin
            errors++;
            $display("FAIL abort_pre: oe/miso %b required 11", {bus.miso_oe, bus.spi_miso});
        end
        bus.spi_cs = 1'b1;
        repeat (SS + 2) @(negedge clk);
        checks++;
        if ({bus.miso_oe, bus.spi_miso} !== 2'b00) begin
            errors++;
            $display("FAIL abort_post: oe/miso %b required 00", {bus.miso_oe, bus.spi_miso});
        end
        repeat (HP) @(negedge clk);
        check_count("abort_word_sent", n_sent - s0, 0);
        src_q.push_back(8'h81);
        exp_q.push_back(8'h81);
        spi_xfer(1, HP);
    endtask

    task automatic test_async_reset;
        logic b;
        src_q.push_back(8'h5A);
        bus.spi_cs = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < 4; i++) sck_pulse(HP, 1'b0, b);
        checks++;
        if ({bus.miso_oe, bus.spi_miso} !== 2'b11) begin
            errors++;
            $display("FAIL rst_pre: oe/miso %b required 11", {bus.miso_oe, bus.spi_miso});
        end
        #2 rst_n = 1'b0;
        #1;
        $display("async reset after 4 bits of 5a");
        checks++;
        if ({bus.spi_miso, bus.miso_oe, bus.tx_ready, bus.word_sent, bus.underrun} !== 5'b0) begin
            errors++;
            $display("FAIL rst_async: got %b required 00000",
                     {bus.spi_miso, bus.miso_oe, bus.tx_ready, bus.word_sent, bus.underrun});
        end
        @(negedge clk);
        bus.spi_cs = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        src_q.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        spi_xfer(1, HP);
    endtask

    task automatic test_slow_margin;
        int r0, s0;
        r0 = n_ready; s0 = n_sent;
        for (int i = 0; i < 4; i++) begin
            src_q.push_back(8'h01 << i);
            exp_q.push_back(8'h01 << i);
        end
        spi_xfer(4, SS + 3);
        check_count("slow_word_sent", n_sent - s0, 4);
        check_count("slow_tx_ready", n_ready - r0, 4);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_async_reset();
        test_slow_margin();
        check_count("exp_queue_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
